// File: rtl/spi_command_sequencer_if.sv
// Register-strobe bus between software and the sequencer, plus the SPI-engine side.
// The slave modport is the sequencer; the master modport is the driver/engine side.
interface spi_command_sequencer_if;
  logic        cmdWrStrobe;
  logic [31:0] cmdData;
  logic        ctlWrStrobe;
  logic [31:0] ctlData;
  logic        rbRdStrobe;
  logic [31:0] rbData;
  logic [31:0] status;
  logic        spiStrobe;
  logic [31:0] spiCommand;
  logic [31:0] spiStatus;

  modport slave (
    input  cmdWrStrobe, cmdData, ctlWrStrobe, ctlData, rbRdStrobe, spiStatus,
    output rbData, status, spiStrobe, spiCommand
  );

  modport master (
    output cmdWrStrobe, cmdData, ctlWrStrobe, ctlData, rbRdStrobe, spiStatus,
    input  rbData, status, spiStrobe, spiCommand
  );
endinterface

// File: rtl/spi_command_sequencer.sv
// Feeds queued SPI command words to the SPI engine one at a time and collects
// each transfer's readback into a readback FIFO tagged with a 7-bit sequence number.
module spi_command_sequencer #(
  parameter int    CMD_AW     = 5,
  parameter int    RB_AW      = 5,
  parameter int    GAP_CYCLES = 4,
  parameter string DEBUG      = "false"
) (
  input logic                    clk,
  input logic                    rst,
  spi_command_sequencer_if.slave bus
);

  localparam int CMD_DEPTH = 1 << CMD_AW;
  localparam int RB_DEPTH  = 1 << RB_AW;
  localparam logic [CMD_AW:0]   CMD_FULL    = (CMD_AW+1)'(CMD_DEPTH);
  localparam logic [CMD_AW:0]   CMD_CNT_INC = (CMD_AW+1)'(1);
  localparam logic [CMD_AW-1:0] CMD_PTR_INC = CMD_AW'(1);
  localparam logic [RB_AW:0]    RB_FULL     = (RB_AW+1)'(RB_DEPTH);
  localparam logic [RB_AW:0]    RB_CNT_INC  = (RB_AW+1)'(1);
  localparam logic [RB_AW-1:0]  RB_PTR_INC  = RB_AW'(1);
  localparam logic [7:0]        GAP_LAST    = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    CAPTURE = 3'd4,
    GAP     = 3'd5
  } state_e;

  state_e            state_q, state_d, state_obs_s;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [31:0]       cmd_mem_q [CMD_DEPTH];
  logic [30:0]       rb_mem_q  [RB_DEPTH];
  logic [CMD_AW-1:0] cmd_wp_q, cmd_rp_q;
  logic [CMD_AW:0]   cmd_cnt_q;
  logic [RB_AW-1:0]  rb_wp_q, rb_rp_q;
  logic [RB_AW:0]    rb_cnt_q;
  logic [6:0]        seq_q;
  logic              cmd_ovf_q, cmd_ovf_d;
  logic              rb_unf_q, rb_unf_d;
  logic              cap_en_q;
  logic              flush_pend_q, flush_pend_d;
  logic              spi_strobe_q, spi_strobe_d;
  logic [31:0]       spi_cmd_q, spi_cmd_d;
  logic              issue_s, rb_push_s, seq_adv_s;

  wire busy_s      = bus.spiStatus[31];
  wire flush_s     = bus.ctlWrStrobe & bus.ctlData[0];
  wire clear_s     = bus.ctlWrStrobe & bus.ctlData[2];
  wire cmd_empty_s = (cmd_cnt_q == '0);
  wire cmd_full_s  = (cmd_cnt_q == CMD_FULL);
  wire rb_empty_s  = (rb_cnt_q == '0);
  wire rb_full_s   = (rb_cnt_q == RB_FULL);
  wire cmd_push_s  = bus.cmdWrStrobe & ~cmd_full_s & ~flush_s;
  wire cmd_pop_s   = issue_s;
  wire rb_pop_s    = bus.rbRdStrobe & ~rb_empty_s & ~flush_s;
  wire can_issue_s = ~cmd_empty_s & ~busy_s & (~cap_en_q | ~rb_full_s) & ~flush_s;
  wire active_s    = (state_obs_s != IDLE) | ~cmd_empty_s;

  logic unused_bits_s;
  assign unused_bits_s = ^{bus.ctlData[31:3], bus.spiStatus[30:24]};

  generate
    if (DEBUG == "true") begin : g_dbg
      (* mark_debug = "true" *) state_e dbg_state_s;
      assign dbg_state_s = state_q;
      assign state_obs_s = dbg_state_s;
    end else begin : g_nodbg
      assign state_obs_s = state_q;
    end
  endgenerate

  // State register and all sequencer/FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gap_cnt_q    <= 8'd0;
      cmd_wp_q     <= '0;
      cmd_rp_q     <= '0;
      cmd_cnt_q    <= '0;
      rb_wp_q      <= '0;
      rb_rp_q      <= '0;
      rb_cnt_q     <= '0;
      seq_q        <= 7'd0;
      cmd_ovf_q    <= 1'b0;
      rb_unf_q     <= 1'b0;
      cap_en_q     <= 1'b1;
      flush_pend_q <= 1'b0;
      spi_strobe_q <= 1'b0;
      spi_cmd_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      spi_strobe_q <= spi_strobe_d;
      spi_cmd_q    <= spi_cmd_d;
      cmd_ovf_q    <= cmd_ovf_d;
      rb_unf_q     <= rb_unf_d;
      flush_pend_q <= flush_pend_d;
      if (bus.ctlWrStrobe) cap_en_q <= bus.ctlData[1];
      if (flush_s) begin
        cmd_wp_q  <= '0;
        cmd_rp_q  <= '0;
        cmd_cnt_q <= '0;
        rb_wp_q   <= '0;
        rb_rp_q   <= '0;
        rb_cnt_q  <= '0;
        seq_q     <= 7'd0;
      end else begin
        if (cmd_push_s) cmd_wp_q <= cmd_wp_q + CMD_PTR_INC;
        if (cmd_pop_s)  cmd_rp_q <= cmd_rp_q + CMD_PTR_INC;
        if (cmd_push_s && !cmd_pop_s) cmd_cnt_q <= cmd_cnt_q + CMD_CNT_INC;
        else if (!cmd_push_s && cmd_pop_s) cmd_cnt_q <= cmd_cnt_q - CMD_CNT_INC;
        if (rb_push_s) rb_wp_q <= rb_wp_q + RB_PTR_INC;
        if (rb_pop_s)  rb_rp_q <= rb_rp_q + RB_PTR_INC;
        if (rb_push_s && !rb_pop_s) rb_cnt_q <= rb_cnt_q + RB_CNT_INC;
        else if (!rb_push_s && rb_pop_s) rb_cnt_q <= rb_cnt_q - RB_CNT_INC;
        if (seq_adv_s) seq_q <= seq_q + 7'd1;
      end
    end
  end

  // FIFO storage, no reset needed since counts qualify every read
  always_ff @(posedge clk) begin
    if (cmd_push_s) cmd_mem_q[cmd_wp_q] <= bus.cmdData;
    if (rb_push_s)  rb_mem_q[rb_wp_q]   <= {seq_q, bus.spiStatus[23:0]};
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    issue_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_issue_s) begin
          issue_s = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   state_d = WAIT_HI;
      WAIT_HI: state_d = busy_s ? WAIT_LO : WAIT_HI;
      WAIT_LO: state_d = busy_s ? WAIT_LO : CAPTURE;
      CAPTURE: begin
        state_d   = GAP;
        gap_cnt_d = 8'd0;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = IDLE;
          gap_cnt_d = 8'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath control; a flushed transfer neither captures nor advances seq
  always_comb begin
    spi_strobe_d = issue_s;
    spi_cmd_d    = issue_s ? cmd_mem_q[cmd_rp_q] : spi_cmd_q;
    rb_push_s    = (state_q == CAPTURE) & cap_en_q & ~flush_pend_q & ~flush_s;
    seq_adv_s    = (state_q == CAPTURE) & ~flush_pend_q;
    if (flush_s && (state_q == ISSUE || state_q == WAIT_HI || state_q == WAIT_LO)) begin
      flush_pend_d = 1'b1;
    end else if (state_q == CAPTURE) begin
      flush_pend_d = 1'b0;
    end else begin
      flush_pend_d = flush_pend_q;
    end
    if (bus.cmdWrStrobe && cmd_full_s) cmd_ovf_d = 1'b1;
    else if (clear_s)                  cmd_ovf_d = 1'b0;
    else                               cmd_ovf_d = cmd_ovf_q;
    if (bus.rbRdStrobe && rb_empty_s)  rb_unf_d = 1'b1;
    else if (clear_s)                  rb_unf_d = 1'b0;
    else                               rb_unf_d = rb_unf_q;
  end

  assign bus.spiStrobe  = spi_strobe_q;
  assign bus.spiCommand = spi_cmd_q;
  assign bus.rbData     = rb_empty_s ? 32'd0 : {1'b1, rb_mem_q[rb_rp_q]};
  assign bus.status     = {active_s, cmd_ovf_q, rb_unf_q, cap_en_q, 4'd0,
                           8'(rb_cnt_q), 8'(cmd_cnt_q), 8'd0};

endmodule

// File: tb/tb_spi_command_sequencer.sv
// Directed plus randomized bench for spi_command_sequencer, with a simple SPI engine
// model (busy for 50 clocks after each strobe, readback = low 24 bits of the command).
module tb_spi_command_sequencer;
  localparam int GAP      = 4;
  localparam int BUSY_LEN = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_command_sequencer_if b0 ();
  spi_command_sequencer_if b1 ();

  spi_command_sequencer #(.CMD_AW(5), .RB_AW(5), .GAP_CYCLES(GAP), .DEBUG("false"))
    u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  spi_command_sequencer #(.CMD_AW(5), .RB_AW(1), .GAP_CYCLES(GAP), .DEBUG("false"))
    u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine models
  int bcnt0 = 0, bcnt1 = 0;
  logic hold0 = 1'b0;
  logic [23:0] rbv0 = 24'd0, rbv1 = 24'd0;
  wire busy0 = hold0 | (bcnt0 != 0);
  wire busy1 = (bcnt1 != 0);
  assign b0.spiStatus = {busy0, 7'd0, rbv0};
  assign b1.spiStatus = {busy1, 7'd0, rbv1};
  always @(posedge clk) begin
    if (b0.spiStrobe === 1'b1) begin bcnt0 <= BUSY_LEN; rbv0 <= b0.spiCommand[23:0]; end
    else if (bcnt0 > 0) bcnt0 <= bcnt0 - 1;
    if (b1.spiStrobe === 1'b1) begin bcnt1 <= BUSY_LEN; rbv1 <= b1.spiCommand[23:0]; end
    else if (bcnt1 > 0) bcnt1 <= bcnt1 - 1;
  end

  // Strobe monitors: issued words, gap since last busy fall, back-to-back strobes
  logic [31:0] sq0[$], sq1[$];
  int sgap0[$];
  int dbl0 = 0, lfall0 = 0;
  logic pstb0 = 1'b0, pstb1 = 1'b0, pbusy0 = 1'b0, fv0 = 1'b0;
  int dbl1 = 0;
  always @(negedge clk) begin
    if (b0.spiStrobe === 1'b1) begin
      sq0.push_back(b0.spiCommand);
      sgap0.push_back(fv0 ? (cyc - lfall0) : -1);
      fv0 <= 1'b0;
      if (pstb0) dbl0 <= dbl0 + 1;
    end else if (pbusy0 && !busy0) begin
      lfall0 <= cyc;
      fv0    <= 1'b1;
    end
    if (b1.spiStrobe === 1'b1) begin
      sq1.push_back(b1.spiCommand);
      if (pstb1) dbl1 <= dbl1 + 1;
    end
    pstb0  <= (b0.spiStrobe === 1'b1);
    pstb1  <= (b1.spiStrobe === 1'b1);
    pbusy0 <= busy0;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [31:0] d);
    b0.cmdWrStrobe = 1'b1; b0.cmdData = d; tick(); b0.cmdWrStrobe = 1'b0;
  endtask
  task automatic push1(input logic [31:0] d);
    b1.cmdWrStrobe = 1'b1; b1.cmdData = d; tick(); b1.cmdWrStrobe = 1'b0;
  endtask
  task automatic ctl0(input logic [31:0] d);
    b0.ctlWrStrobe = 1'b1; b0.ctlData = d; tick(); b0.ctlWrStrobe = 1'b0;
  endtask
  task automatic pop0(output logic [31:0] v);
    v = b0.rbData; b0.rbRdStrobe = 1'b1; tick(); b0.rbRdStrobe = 1'b0;
  endtask
  task automatic pop1(output logic [31:0] v);
    v = b1.rbData; b1.rbRdStrobe = 1'b1; tick(); b1.rbRdStrobe = 1'b0;
  endtask

  // Reference readback word: valid flag, 7-bit wrapping sequence, low 24 bits of command
  function automatic logic [31:0] rb_word(input int seq, input logic [31:0] cmd);
    return {1'b1, 7'(seq % 128), cmd[23:0]};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, x;
    logic [31:0] cmds[3];
    logic [31:0] c1[4];
    logic [31:0] words[$];
    logic ce;
    int seq_m0, base, n;

    b0.cmdWrStrobe = 1'b0; b0.cmdData = 32'd0; b0.ctlWrStrobe = 1'b0;
    b0.ctlData = 32'd0; b0.rbRdStrobe = 1'b0;
    b1.cmdWrStrobe = 1'b0; b1.cmdData = 32'd0; b1.ctlWrStrobe = 1'b0;
    b1.ctlData = 32'd0; b1.rbRdStrobe = 1'b0;
    seq_m0 = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("reset_status", b0.status, 32'h1000_0000);
    chk("reset_rbdata", b0.rbData, 32'd0);
    chk("reset_strobe", 32'(b0.spiStrobe), 32'd0);
    chk("reset_command", b0.spiCommand, 32'd0);
    chk("reset_status_rb1", b1.status, 32'h1000_0000);

    // Three commands, in-order issue, latency, gaps, readback
    cmds[0] = 32'h8012_3456; cmds[1] = 32'h0000_1234; cmds[2] = 32'h8F00_AA55;
    push0(cmds[0]);
    chk("latency_not_yet", 32'(b0.spiStrobe), 32'd0);
    push0(cmds[1]);
    chk("latency_strobe", 32'(b0.spiStrobe), 32'd1);
    push0(cmds[2]);
    for (int k = 0; k < 1000 && sq0.size() < 3; k++) tick();
    for (int k = 0; k < 200 && b0.status[31]; k++) tick();
    chk("three_strobes", 32'(sq0.size()), 32'd3);
    chk("three_idle", 32'(b0.status[31]), 32'd0);
    for (int i = 0; i < 3; i++)
      if (i < sq0.size()) chk("strobe_order", sq0[i], cmds[i]);
    chk("strobe_width", 32'(dbl0), 32'd0);
    for (int i = 1; i < 3; i++)
      if (i < sgap0.size()) chk("busy_fall_to_strobe", 32'(sgap0[i]), 32'(GAP + 3));
    for (int i = 0; i < 3; i++) begin
      pop0(v);
      chk("rb_pop", v, rb_word(seq_m0, cmds[i]));
      seq_m0++;
    end
    chk("rb_first_literal", rb_word(0, cmds[0]), 32'h8012_3456);
    chk("rb_drained", b0.rbData, 32'd0);

    // Overflow while the engine is held busy
    hold0 = 1'b1;
    base = sq0.size();
    for (int i = 0; i < 33; i++) push0($urandom);
    chk("ovf_count", 32'(b0.status[15:8]), 32'd32);
    chk("ovf_flag", 32'(b0.status[30]), 32'd1);
    chk("ovf_active", 32'(b0.status[31]), 32'd1);
    ctl0(32'h4);
    chk("ovf_cleared", 32'(b0.status[30]), 32'd0);
    chk("capen_off", 32'(b0.status[28]), 32'd0);
    ctl0(32'h3);
    chk("flush_cmd_count", 32'(b0.status[15:8]), 32'd0);
    chk("capen_on", 32'(b0.status[28]), 32'd1);
    hold0 = 1'b0;
    repeat (5) tick();
    chk("no_strobe_while_held", 32'(sq0.size()), 32'(base));
    seq_m0 = 0;

    // Readback FIFO of depth 2 throttles issue
    for (int i = 0; i < 4; i++) begin c1[i] = $urandom; push1(c1[i]); end
    for (int k = 0; k < 600 && sq1.size() < 2; k++) tick();
    repeat (150) tick();
    chk("rbfull_strobes", 32'(sq1.size()), 32'd2);
    chk("rbfull_active", 32'(b1.status[31]), 32'd1);
    chk("rbfull_rb_count", 32'(b1.status[23:16]), 32'd2);
    chk("rbfull_cmd_count", 32'(b1.status[15:8]), 32'd2);
    pop1(v);
    chk("rbfull_pop0", v, rb_word(0, c1[0]));
    for (int k = 0; k < 300 && sq1.size() < 3; k++) tick();
    chk("rbfull_third", 32'(sq1.size()), 32'd3);
    pop1(v);
    chk("rbfull_pop1", v, rb_word(1, c1[1]));
    for (int k = 0; k < 400 && b1.status[31]; k++) tick();
    for (int i = 0; i < 4; i++)
      if (i < sq1.size()) chk("rbfull_order", sq1[i], c1[i]);
    pop1(v); chk("rbfull_pop2", v, rb_word(2, c1[2]));
    pop1(v); chk("rbfull_pop3", v, rb_word(3, c1[3]));
    chk("rbfull_width", 32'(dbl1), 32'd0);

    // Flush during the first of five transfers
    base = sq0.size();
    for (int i = 0; i < 5; i++) push0($urandom);
    for (int k = 0; k < 50 && sq0.size() < base + 1; k++) tick();
    for (int k = 0; k < 20 && !busy0; k++) tick();
    repeat (5) tick();
    ctl0(32'h3);
    repeat (200) tick();
    chk("flush_strobes", 32'(sq0.size()), 32'(base + 1));
    chk("flush_counts", b0.status & 32'h00FF_FF00, 32'd0);
    chk("flush_rbdata", b0.rbData, 32'd0);
    chk("flush_idle", 32'(b0.status[31]), 32'd0);
    x = $urandom;
    push0(x);
    for (int k = 0; k < 300 && (sq0.size() < base + 2 || b0.status[31]); k++) tick();
    pop0(v);
    chk("flush_next_seq0", v, rb_word(0, x));

    // Reset while the engine is busy
    push0($urandom);
    for (int k = 0; k < 20 && !busy0; k++) tick();
    repeat (3) tick();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("rst_busy_strobe", 32'(b0.spiStrobe), 32'd0);
    chk("rst_busy_status", b0.status, 32'h1000_0000);
    chk("rst_busy_command", b0.spiCommand, 32'd0);
    base = sq0.size();
    x = $urandom;
    push0(x);
    for (int k = 0; k < 100 && busy0; k++) tick();
    chk("no_issue_while_busy", 32'(sq0.size()), 32'(base));
    for (int k = 0; k < 300 && (sq0.size() < base + 1 || b0.status[31]); k++) tick();
    if (base < sq0.size()) chk("post_reset_cmd", sq0[base], x);
    pop0(v);
    chk("post_reset_rb", v, rb_word(0, x));
    seq_m0 = 1;

    // Readback underflow
    b0.rbRdStrobe = 1'b1; tick(); b0.rbRdStrobe = 1'b0;
    chk("unf_flag", 32'(b0.status[29]), 32'd1);
    chk("unf_rbdata", b0.rbData, 32'd0);
    chk("unf_count", 32'(b0.status[23:16]), 32'd0);
    ctl0(32'h6);
    chk("unf_cleared", 32'(b0.status[29]), 32'd0);

    // Randomized rounds against the queue model
    for (int r = 0; r < 6; r++) begin
      words.delete();
      ce = ($urandom_range(0, 3) != 0);
      ctl0({29'd0, 1'b0, ce, 1'b0});
      n = $urandom_range(1, 6);
      base = sq0.size();
      for (int i = 0; i < n; i++) begin
        x = $urandom;
        words.push_back(x);
        push0(x);
      end
      for (int k = 0; k < 1500 && sq0.size() < base + n; k++) tick();
      for (int k = 0; k < 200 && b0.status[31]; k++) tick();
      chk("rnd_strobe_count", 32'(sq0.size()), 32'(base + n));
      chk("rnd_idle", 32'(b0.status[31]), 32'd0);
      for (int i = 0; i < n; i++)
        if (base + i < sq0.size()) chk("rnd_strobe_order", sq0[base + i], words[i]);
      if (ce) begin
        for (int i = 0; i < n; i++) begin
          pop0(v);
          chk("rnd_rb", v, rb_word(seq_m0, words[i]));
          seq_m0++;
        end
      end else begin
        seq_m0 += n;
      end
      chk("rnd_rb_empty", b0.rbData, 32'd0);
    end
    chk("final_width", 32'(dbl0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
